// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous sprite ROM read port among NUM_REQ pixel requesters.
// Composes frame*FRAME_WORDS+offset, and returns tagged palette data two cycles after each grant.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned OFS_W       = 12,
  parameter int unsigned FRAME_W     = 2,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned FRAME_WORDS = 2640,
  parameter int unsigned ROM_AW      = 14,
  parameter int unsigned DATA_W      = 4
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*OFS_W-1:0]   req_offset,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
  output logic [NUM_REQ-1:0]         grant,
  output logic [ROM_AW-1:0]          rom_address,
  input  logic [DATA_W-1:0]          rom_q,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FW_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned MUL_W = FRAME_W + FW_W;
  // One guard bit above the wider addend keeps the sum from overflowing.
  localparam int unsigned SUM_W = ((MUL_W > OFS_W) ? MUL_W : OFS_W) + 1;

  logic [OFS_W-1:0]   ofs_a [NUM_REQ];
  logic [FRAME_W-1:0] frm_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign ofs_a[gi] = req_offset[gi*OFS_W +: OFS_W];
    assign frm_a[gi] = req_frame[gi*FRAME_W +: FRAME_W];
  end

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ROM_AW-1:0]  rom_address_q, rom_address_d;
  logic               err1_q, err1_d;
  logic [NUM_REQ-1:0] v2_q, v2_d;
  logic               err2_q, err2_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               found;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   cand;
  logic [SUM_W-1:0]   frame_x;
  logic [SUM_W-1:0]   ofs_x;
  logic [SUM_W-1:0]   addr_full;
  logic               addr_err;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = PTR_W'((32'(ptr_q) + j) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Linear ROM address of the selected requester and its range check.
  always_comb begin
    frame_x   = SUM_W'(frm_a[sel]);
    ofs_x     = SUM_W'(ofs_a[sel]);
    addr_err  = (ofs_x >= SUM_W'(FRAME_WORDS)) || (frame_x >= SUM_W'(NUM_FRAMES));
    addr_full = frame_x * SUM_W'(FRAME_WORDS) + ofs_x;
  end

  always_comb begin
    grant_d       = '0;
    rom_address_d = rom_address_q;
    ptr_d         = ptr_q;
    err1_d        = 1'b0;
    if (found) begin
      grant_d[sel]  = 1'b1;
      err1_d        = addr_err;
      rom_address_d = addr_err ? '0 : ROM_AW'(addr_full);
      ptr_d         = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
    end
  end

  // Tag follows the address through the ROM's one-cycle read, then data is captured.
  always_comb begin
    v2_d        = grant_q;
    err2_d      = err1_q;
    rsp_valid_d = v2_q;
    rsp_err_d   = (|v2_q) && err2_q;
    rsp_data_d  = ((|v2_q) && !err2_q) ? rom_q : '0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= '0;
      grant_q       <= '0;
      rom_address_q <= '0;
      err1_q        <= 1'b0;
      v2_q          <= '0;
      err2_q        <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      rom_address_q <= rom_address_d;
      err1_q        <= err1_d;
      v2_q          <= v2_d;
      err2_q        <= err2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign grant       = grant_q;
  assign rom_address = rom_address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: a reference model predicts grants, addresses and queued
// responses; a monitor on the falling edge compares the DUT against them.
module tb_sprite_rom_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned OFS_W = 12;
  localparam int unsigned FR_W  = 2;
  localparam int unsigned NF    = 3;
  localparam int unsigned FW    = 2640;
  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 4;

  logic              vga_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*OFS_W-1:0] req_offset = '0;
  logic [N*FR_W-1:0] req_frame = '0;
  logic [N-1:0]      grant;
  logic [AW-1:0]     rom_address;
  logic [DW-1:0]     rom_q = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;

  sprite_rom_arbiter #(
    .NUM_REQ(N), .OFS_W(OFS_W), .FRAME_W(FR_W), .NUM_FRAMES(NF),
    .FRAME_WORDS(FW), .ROM_AW(AW), .DATA_W(DW)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_offset(req_offset),
    .req_frame(req_frame), .grant(grant), .rom_address(rom_address), .rom_q(rom_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [DW-1:0] rom_word(input int unsigned a);
    return DW'(a ^ (a >> 4) ^ (a >> 9) ^ 5);
  endfunction

  // Synchronous ROM: one cycle from address to data.
  always @(posedge vga_clk) rom_q <= rom_word(32'(rom_address));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned due;
    int unsigned k;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  int unsigned   cyc = 0;
  int unsigned   ptr_m = 0;
  logic [N-1:0]  exp_grant = '0;
  logic [AW-1:0] exp_addr = '0;

  // Reference model: round-robin choice, address arithmetic, response due two edges later.
  always @(posedge vga_clk or negedge reset_n) begin : model
    int unsigned k, fr, off, a;
    bit   hit;
    logic e;
    rsp_t r;
    if (!reset_n) begin
      exp_q.delete();
      ptr_m     = 0;
      exp_grant = '0;
      exp_addr  = '0;
    end else begin
      cyc++;
      exp_grant = '0;
      hit = 1'b0;
      k   = 0;
      for (int j = 0; j < N; j++) begin
        if (!hit && req[(ptr_m + j) % N]) begin
          hit = 1'b1;
          k   = (ptr_m + j) % N;
        end
      end
      if (hit) begin
        fr  = 32'(req_frame[k*FR_W +: FR_W]);
        off = 32'(req_offset[k*OFS_W +: OFS_W]);
        e   = (off >= FW) || (fr >= NF);
        a   = e ? 0 : (fr * FW + off) % (1 << AW);
        exp_grant[k] = 1'b1;
        exp_addr     = AW'(a);
        ptr_m        = (k + 1) % N;
        r.due  = cyc + 2;
        r.k    = k;
        r.err  = e;
        r.data = e ? '0 : rom_word(a);
        exp_q.push_back(r);
      end
    end
  end

  // Monitor: grant/address every cycle, responses popped from the scoreboard when due.
  always @(negedge vga_clk) begin : monitor
    rsp_t r;
    chk("grant", 64'(grant), 64'(exp_grant));
    chk("rom_address", 64'(rom_address), 64'(exp_addr));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << r.k);
      chk("rsp_data", 64'(rsp_data), 64'(r.data));
      chk("rsp_err", 64'(rsp_err), 64'(r.err));
    end else begin
      chk("rsp_idle", 64'({rsp_valid, rsp_data, rsp_err}), 64'(0));
    end
  end

  task automatic step();
    @(posedge vga_clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit r, input int unsigned fr, input int unsigned off);
    req[i] = r;
    req_frame[i*FR_W +: FR_W]    = FR_W'(fr);
    req_offset[i*OFS_W +: OFS_W] = OFS_W'(off);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_addr"}, 64'(rom_address), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge vga_clk);
    #2 reset_n = 1'b1;
    step();

    // All four requesting continuously: rotation from requester 0.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i % NF, 100 + i);
    repeat (6) step();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);
    repeat (3) step();

    // Single requester 2, frame 1 offset 5, held five cycles.
    set_req(2, 1'b1, 1, 5);
    step();
    chk("addr_2645", 64'(rom_address), 64'd2645);
    repeat (4) step();
    set_req(2, 1'b0, 0, 0);
    // Idle gap: address holds.
    repeat (3) step();
    chk("addr_hold", 64'(rom_address), 64'd2645);

    // Pointer fairness: after 3, req0+req1 -> 0; after 0, req0+req1 -> 1.
    set_req(3, 1'b1, 2, 7);
    step();
    set_req(3, 1'b0, 0, 0);
    set_req(0, 1'b1, 0, 11);
    set_req(1, 1'b1, 1, 12);
    step();
    chk("fair_0_wins", 64'(grant), 64'b0001);
    set_req(0, 1'b0, 0, 0);
    step();
    set_req(1, 1'b0, 0, 0);
    set_req(0, 1'b1, 2, 13);
    step();
    set_req(1, 1'b1, 0, 14);
    step();
    chk("fair_1_wins", 64'(grant), 64'b0010);
    set_req(1, 1'b0, 0, 0);
    step();
    set_req(0, 1'b0, 0, 0);
    repeat (2) step();

    // Out-of-range offset and out-of-range frame.
    set_req(1, 1'b1, 0, 2640);
    step();
    chk("err_addr_ofs", 64'(rom_address), 64'd0);
    set_req(1, 1'b0, 0, 0);
    set_req(2, 1'b1, 3, 20);
    step();
    chk("err_addr_frm", 64'(rom_address), 64'd0);
    set_req(2, 1'b0, 0, 0);
    repeat (3) step();

    // Reset mid-stream with grants in flight.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1, 200 + i);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2, 300 + i);
    step();
    chk("ptr_after_reset", 64'(grant), 64'b0001);
    repeat (4) step();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);
    repeat (3) step();

    // Random traffic obeying the hold-until-granted handshake.
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !grant[i]) begin
          // keep pending request stable
        end else if ($urandom_range(0, 9) < 6) begin
          set_req(i, 1'b1, $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(2640, 4095) : $urandom_range(0, 2639));
        end else begin
          set_req(i, 1'b0, 0, 0);
        end
      end
      step();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);
    repeat (5) step();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM read port (e.g. an enemy running-frame ROM) among NUM_REQ pixel requesters, such as several on-screen enemy instances that use the same sprite sheet.
- Each requester supplies a frame index and an in-frame pixel offset.
- The block arbitrates round-robin, composes the linear ROM address, drives the ROM, and returns the palette index to the granted requester with a tagged valid.
- Position: between the per-sprite mappers and the shared *_rom instance. The palette lookup stays downstream in each mapper.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- OFS_W, 12: width of the per-frame pixel offset.
- FRAME_W, 2: width of the frame index.
- NUM_FRAMES, 4: valid frames; frame >= NUM_FRAMES is an error.
- FRAME_WORDS, 2640: words per frame (40x66 sprite).
- ROM_AW, 14: ROM address width. Must satisfy ROM_AW >= clog2(NUM_FRAMES*FRAME_WORDS).
- DATA_W, 4: ROM word (palette index) width.

Ports:
- vga_clk, input, 1: pixel clock, rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- req, input, NUM_REQ: per-requester read request, level.
- req_offset, input, NUM_REQ*OFS_W: flattened offsets; requester i occupies bits [i*OFS_W +: OFS_W].
- req_frame, input, NUM_REQ*FRAME_W: flattened frame indices, same packing.
- grant, output, NUM_REQ: registered one-hot grant, high for exactly one cycle per accepted request.
- rom_address, output, ROM_AW: registered address to the shared ROM.
- rom_q, input, DATA_W: ROM data, valid one cycle after rom_address is sampled by the ROM.
- rsp_valid, output, NUM_REQ: one-hot response strobe.
- rsp_data, output, DATA_W: returned palette index.
- rsp_err, output, 1: response carries an out-of-range access.

Behaviour:
- Reset (asynchronous assert, synchronous release): grant, rsp_valid, rsp_err, rsp_data and rom_address are all 0. The RR pointer resets to 0, so requester 0 has highest priority first. In-flight pipeline valids are cleared. Responses from requests accepted before reset are never delivered.
- Arbitration at each rising edge E0:
  - If any req is high, pick the first requester at or after the pointer, in wrap-around order.
  - Register grant[k]=1 and rom_address = req_frame[k]*FRAME_WORDS + req_offset[k], truncated to ROM_AW.
  - Pointer becomes (k+1) mod NUM_REQ.
  - If no req is high: grant=0, and both rom_address and pointer hold.
- Handshake:
  - A requester holds req, offset and frame stable until it sees grant[i] high.
  - If it still has req high at the edge after its grant, that is a new request.
  - Throughput: one grant per cycle, fully pipelined.
- Latency:
  - Grant at E0. The ROM samples the address at E1. rsp_valid[k], rsp_data and rsp_err are registered at E2.
  - Response arrives exactly 2 cycles after the grant edge, in grant order.
  - rsp_valid is a one-cycle pulse.
- Error case (offset >= FRAME_WORDS or frame >= NUM_FRAMES):
  - The request is still granted normally and the pointer still advances.
  - rom_address is forced to 0.
  - At E2: rsp_err=1 and rsp_data=0, regardless of rom_q.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0…. No requester waits more than NUM_REQ-1 cycles.
- Single requester: granted every cycle while req is held high.
- Arithmetic: the multiply uses widths wide enough that it never overflows before truncation. FRAME_WORDS is a constant, so this is a constant multiply.
- rsp_err, rsp_valid and rsp_data return to 0 on cycles with no response.

Test Plan:
- Reset: reset_n=0 mid-stream with grants issued in the prior 2 cycles → all outputs 0 immediately. No rsp_valid after release until a new grant plus 2 cycles.
- Single requester, req[2] held 5 cycles, frame=1, offset=5:
  - grant=0100 on each edge; rom_address=2645.
  - rsp_valid=0100 two cycles after each grant.
  - rsp_data equals the ROM model word at 2645.
- All 4 requesting continuously from reset → grant sequence 0001,0010,0100,1000,0001. Responses follow in the same order, each 2 cycles later.
- Pointer fairness:
  - After granting req 3, req0 and req1 assert together → req0 wins.
  - After granting req 0, req0 and req1 assert together → req1 wins.
- Errors:
  - offset=2640, frame=0 → granted, rom_address=0; 2 cycles later rsp_err=1, rsp_data=0.
  - Same result for frame=3 with NUM_FRAMES=3.
- Idle gaps: req low for 3 cycles → grant=0 and rom_address holds its last value. No spurious rsp_valid.
